// File: rtl/jt49_dcrm.sv
// jt49_dcrm: DC-removal stage for the jt49 PSG output.
// Subtracts the running mean of the last 2^AW accepted samples and emits a signed sample.
module jt49_dcrm #(
    parameter int unsigned DW = 10,
    parameter int unsigned AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic [DW-1:0]        din,
    output logic signed [DW:0]   dout,
    output logic                 dout_valid,
    output logic                 settled
);
    localparam int unsigned Depth = 1 << AW;
    localparam int unsigned SW = DW + AW;
    localparam logic [AW:0] FillMax = (AW+1)'(Depth);

    logic [DW-1:0] r_mem [Depth];
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_fill;
    logic [SW-1:0] r_sum;
    logic [DW-1:0] r_d1;
    logic [DW-1:0] r_o1;
    logic [DW-1:0] r_d2;
    logic          r_v1;
    logic          r_v2;
    logic          r_s1;
    logic          r_s2;

    logic          w_full;
    logic [DW-1:0] w_old;
    logic [SW-1:0] w_sum_nxt;
    logic [DW-1:0] w_mean;

    // While filling, ptr equals the fill count, so the addressed slot is never yet written.
    always_comb begin
        w_full    = (r_fill == FillMax);
        w_old     = w_full ? r_mem[r_ptr] : '0;
        w_sum_nxt = r_sum + SW'(r_d1) - SW'(r_o1);
        w_mean    = r_sum[SW-1:AW];
    end

    always_ff @(posedge clk) begin
        if (cen && !rst) begin
            r_mem[r_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_fill     <= '0;
            r_sum      <= '0;
            r_d1       <= '0;
            r_o1       <= '0;
            r_d2       <= '0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            settled    <= 1'b0;
        end else begin
            r_v1 <= cen;
            if (cen) begin
                r_d1  <= din;
                r_o1  <= w_old;
                r_s1  <= (r_fill >= FillMax - 1'b1);
                r_ptr <= r_ptr + 1'b1;
                if (!w_full) begin
                    r_fill <= r_fill + 1'b1;
                end
            end

            r_v2 <= r_v1;
            if (r_v1) begin
                r_sum <= w_sum_nxt;
                r_d2  <= r_d1;
                r_s2  <= r_s1;
            end

            // r_sum already includes this sample and not yet the next one.
            dout_valid <= r_v2;
            if (r_v2) begin
                dout <= $signed({1'b0, r_d2}) - $signed({1'b0, w_mean});
                if (r_s2) begin
                    settled <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_jt49_dcrm.sv
// Bench for jt49_dcrm: table-driven constant-input vectors, hand-written corner sequences
// and randomized traffic checked against a sliding-window mean model.
module tb_jt49_dcrm;
    localparam int unsigned DW = 10;
    localparam int unsigned AW = 5;
    localparam int Win = 1 << AW;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cen = 1'b0;
    logic [DW-1:0]       din = '0;
    logic signed [DW:0]  dout;
    logic                dout_valid;
    logic                settled;

    always #5 clk = ~clk;

    jt49_dcrm #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .settled    (settled)
    );

    typedef struct {
        int dout;
        int due;
        bit settled;
    } exp_t;

    typedef struct {
        int din;
        int exp_dout;
        bit exp_settled;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   win_q[$];
    int   n_acc = 0;
    exp_t pend[$];
    int   m_dout = 0;
    bit   m_valid = 1'b0;
    bit   m_settled = 1'b0;
    vec_t tbl[40];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input bit r, input bit c, input int d);
        int   s;
        exp_t e;
        rst = r;
        cen = c;
        din = DW'(d);
        @(posedge clk);
        cyc++;
        if (r) begin
            win_q.delete();
            pend.delete();
            n_acc     = 0;
            m_dout    = 0;
            m_settled = 1'b0;
        end else if (c) begin
            win_q.push_back(d);
            if (win_q.size() > Win) void'(win_q.pop_front());
            s = 0;
            foreach (win_q[i]) s += win_q[i];
            n_acc++;
            e.dout    = d - s / Win;
            e.due     = cyc + 2;
            e.settled = (n_acc >= Win);
            pend.push_back(e);
        end
        m_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e       = pend.pop_front();
            m_valid = 1'b1;
            m_dout  = e.dout;
            if (e.settled) m_settled = 1'b1;
        end
        #1;
        check("model_valid", int'(dout_valid), int'(m_valid));
        check("model_dout", int'($signed(dout)), m_dout);
        check("model_settled", int'(settled), int'(m_settled));
    endtask

    initial begin
        for (int k = 1; k <= 40; k++) begin
            int kk;
            kk = (k < Win) ? k : Win;
            tbl[k-1] = '{din: 600, exp_dout: 600 - (600 * kk) / Win, exp_settled: (k >= Win)};
        end

        // Reset with random traffic, then first cycle after release.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'(($urandom) & 1), int'($urandom_range(0, 1023)));
            check("rst_valid", int'(dout_valid), 0);
            check("rst_dout", int'($signed(dout)), 0);
            check("rst_settled", int'(settled), 0);
        end
        step(1'b0, 1'b0, 0);
        check("rel_valid", int'(dout_valid), 0);
        check("rel_dout", int'($signed(dout)), 0);
        check("rel_settled", int'(settled), 0);

        // Constant 600, one strobe every 4 cycles.
        foreach (tbl[i]) begin
            step(1'b0, 1'b1, tbl[i].din);
            step(1'b0, 1'b0, 0);
            check("tbl_early_valid", int'(dout_valid), 0);
            step(1'b0, 1'b0, 0);
            check("tbl_valid", int'(dout_valid), 1);
            check("tbl_dout", int'($signed(dout)), tbl[i].exp_dout);
            check("tbl_settled", int'(settled), int'(tbl[i].exp_settled));
            step(1'b0, 1'b0, 0);
            check("tbl_late_valid", int'(dout_valid), 0);
            check("tbl_hold", int'($signed(dout)), tbl[i].exp_dout);
        end

        // Settle on 0, then alternate 1023/0.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 0);
        for (int i = 0; i < 63; i++) step(1'b0, 1'b1, (i % 2 == 0) ? 1023 : 0);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        check("alt_high", int'($signed(dout)), 512);
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        check("alt_low", int'($signed(dout)), -511);

        // Back-to-back constant 600.
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 42; i++) begin
            step(1'b0, (i < 40), 600);
            if (i >= 2) begin
                check("b2b_valid", int'(dout_valid), 1);
                check("b2b_dout", int'($signed(dout)), tbl[i-2].exp_dout);
            end else begin
                check("b2b_pre_valid", int'(dout_valid), 0);
            end
        end

        // Reset with two samples in flight.
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 600);
        step(1'b1, 1'b1, 600);
        step(1'b0, 1'b0, 0);
        check("mid_rst_v0", int'(dout_valid), 0);
        step(1'b0, 1'b0, 0);
        check("mid_rst_v1", int'(dout_valid), 0);
        step(1'b0, 1'b1, 600);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        check("mid_rst_first", int'($signed(dout)), 582);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 600);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        check("mid_rst_unsettled", int'(settled), 0);
        step(1'b0, 1'b1, 600);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        check("mid_rst_settled", int'(settled), 1);

        // Full scale then step to zero.
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 34; i++) begin
            step(1'b0, (i < 32), 1023);
            if (i == 2) check("fs_first", int'($signed(dout)), 992);
        end
        check("fs_settled_out", int'($signed(dout)), 0);
        check("fs_sum", int'(dut.r_sum), 32736);
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        check("fs_step", int'($signed(dout)), -991);

        // Random traffic with occasional resets.
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), 1'(($urandom) & 1),
                 int'($urandom_range(0, 1023)));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
